intermediator_input_scheduler: RTL

- Sits in front of the intermediator write ports.
- Merges NUM_LANES multiplier output lanes onto port 0 (wr0/row0/v0) using round-robin arbitration, and honours the intermediator stall.
- Forwards adder write-backs onto port 1 (wr1/row1/v1) unconditionally.
- Sequences end-of-matrix: once every lane is done and the adder loop has gone quiet, it issues a single-cycle eof pulse.

---
 rtl/intermediator_input_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/intermediator_input_scheduler.sv
// Round-robin merge of multiplier lanes onto intermediator port 0, adder passthrough on port 1,
// and end-of-matrix sequencing. Optional stall statistic: define INTERMEDIATOR_SCHED_STATS_EN.
module intermediator_input_scheduler #(
    parameter int NUM_LANES                = 4,
    parameter int LOG2_INTERMEDIATOR_DEPTH = 10,
    parameter int QUIET_CYCLES             = 64
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [NUM_LANES-1:0]                         i_lane_valid,
    input  logic [NUM_LANES*LOG2_INTERMEDIATOR_DEPTH-1:0] i_lane_row,
    input  logic [NUM_LANES*66-1:0]                      i_lane_value,
    output logic [NUM_LANES-1:0]                         o_lane_ready,
    input  logic [NUM_LANES-1:0]                         i_lane_done,
    input  logic                                         i_add_valid,
    input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0]          i_add_row,
    input  logic [65:0]                                  i_add_value,
    input  logic                                         i_stall,
    output logic                                         o_wr0,
    output logic [LOG2_INTERMEDIATOR_DEPTH-1:0]          o_row0,
    output logic [65:0]                                  o_v0,
    output logic                                         o_wr1,
    output logic [LOG2_INTERMEDIATOR_DEPTH-1:0]          o_row1,
    output logic [65:0]                                  o_v1,
    output logic                                         o_eof,
    output logic [31:0]                                  o_stall_cycles
);

    localparam int ROW_W = LOG2_INTERMEDIATOR_DEPTH;
    localparam int VAL_W = 66;
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PTR_W-1:0] PTR_RESET  = PTR_W'(NUM_LANES - 1);
    localparam logic [7:0]       QUIET_LAST = 8'(QUIET_CYCLES - 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_EOF   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [PTR_W-1:0] r_ptr;
    logic [1:0]       r_state;
    logic [7:0]       r_quiet;
    logic             r_wr0;
    logic             r_wr1;
    logic [ROW_W-1:0] r_row0;
    logic [VAL_W-1:0] r_v0;
    logic [ROW_W-1:0] r_row1;
    logic [VAL_W-1:0] r_v1;

    logic [NUM_LANES-1:0] w_grant;
    logic                 w_any_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [ROW_W-1:0]     w_grant_row;
    logic [VAL_W-1:0]     w_grant_value;
    logic                 w_drain_busy;
    logic                 w_all_done_idle;

    // Search lanes above the pointer first, then wrap to lane 0 up to the pointer.
    always_comb begin
        w_grant       = '0;
        w_any_grant   = 1'b0;
        w_grant_idx   = r_ptr;
        w_grant_row   = '0;
        w_grant_value = '0;
        if (!i_rst && !i_stall) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!w_any_grant && i_lane_valid[i] && (i > int'(r_ptr))) begin
                    w_any_grant   = 1'b1;
                    w_grant[i]    = 1'b1;
                    w_grant_idx   = PTR_W'(i);
                    w_grant_row   = i_lane_row[i*ROW_W +: ROW_W];
                    w_grant_value = i_lane_value[i*VAL_W +: VAL_W];
                end
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!w_any_grant && i_lane_valid[i] && (i <= int'(r_ptr))) begin
                    w_any_grant   = 1'b1;
                    w_grant[i]    = 1'b1;
                    w_grant_idx   = PTR_W'(i);
                    w_grant_row   = i_lane_row[i*ROW_W +: ROW_W];
                    w_grant_value = i_lane_value[i*VAL_W +: VAL_W];
                end
            end
        end
    end

    assign w_all_done_idle = (&i_lane_done) && !(|i_lane_valid);
    assign w_drain_busy    = i_add_valid || r_wr0 || (|i_lane_valid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= PTR_RESET;
            r_wr0   <= 1'b0;
            r_wr1   <= 1'b0;
            r_state <= S_RUN;
            r_quiet <= '0;
        end else begin
            r_wr0 <= w_any_grant;
            r_wr1 <= i_add_valid;
            if (w_any_grant) begin
                r_ptr <= w_grant_idx;
            end
            case (r_state)
                S_RUN: begin
                    r_quiet <= '0;
                    if (w_all_done_idle) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_busy) begin
                        r_quiet <= '0;
                    end else if (r_quiet == QUIET_LAST) begin
                        r_state <= S_EOF;
                    end else begin
                        r_quiet <= r_quiet + 8'd1;
                    end
                end
                S_EOF: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // Payload registers carry no reset; the write strobes alone qualify them.
    always_ff @(posedge i_clk) begin
        if (w_any_grant) begin
            r_row0 <= w_grant_row;
            r_v0   <= w_grant_value;
        end
        if (i_add_valid) begin
            r_row1 <= i_add_row;
            r_v1   <= i_add_value;
        end
    end

    assign o_lane_ready = w_grant;
    assign o_wr0        = r_wr0;
    assign o_row0       = r_row0;
    assign o_v0         = r_v0;
    assign o_wr1        = r_wr1;
    assign o_row1       = r_row1;
    assign o_v1         = r_v1;
    assign o_eof        = (r_state == S_EOF);

`ifdef INTERMEDIATOR_SCHED_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (i_stall && (|i_lane_valid) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule
